cdf_divider_array: RTL and testbench
====================================

Name: cdf_divider_array

Overview:
- Eight-lane sequential divider that consumes the eight latched CDF words (cdfval_todiv1..8) from the divider memory datapath.
- Produces the histogram-equalized 8-bit values q = floor(cdf * SCALE / divisor), saturated to the output width.
- One shared control FSM drives eight restoring radix-2 dividers, one quotient bit per cycle.
- A start/done handshake hands results to the downstream write-back stage.

Parameters:
- DATA_W, 32: width of each CDF input and of divisor.
- OUT_W, 8: quotient output width; the saturation value is 2^OUT_W-1.
- SCALE, 255: constant multiplier applied to each numerator. Must fit in OUT_W bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, the FSM, counter and datapath hold.
- start  input  1  one-cycle pulse; cdfval_todiv1..8 and divisor are valid in this cycle.
- divisor  input  DATA_W  total pixel count (denominator).
- cdfval_todiv1..cdfval_todiv8  input  DATA_W each  numerators, lanes 1..8.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse; quotients are valid.
- q1..q8  output  OUT_W each  lane quotients.

Behaviour:
- Reset values: busy=0, done=0, q1..q8=0, state IDLE, iteration counter 0.
- Numerator width is NW = DATA_W+OUT_W (40 by default).
  - Lane numerator = cdfval_todivN * SCALE, computed at start, full NW bits, no truncation.
  - Remainder registers are DATA_W+1 bits.
- FSM states: IDLE, DIV, DONE.
  - IDLE: start=1 and enable=1 → latch eight products and divisor, clear remainders, counter=0, set busy=1 → DIV.
  - DIV: each enabled cycle performs one restoring step on all lanes, MSB of numerator first; counter increments. After iteration NW (counter==NW-1) → DONE.
  - DONE: register the saturated quotients into q1..q8, pulse done=1, busy=0 → IDLE.
- Latency:
  - start sampled at edge 0 with enable held high → iterations on edges 1..NW → q and done update at edge NW+1.
  - done is high for exactly one cycle (41 cycles total by default).
- Saturation: if the full NW-bit quotient exceeds 2^OUT_W-1, output 2^OUT_W-1.
- Divide by zero: divisor==0 latched at start → all lanes output 2^OUT_W-1 with the same latency; no X propagation.
- enable low: state, counter, remainders and outputs are frozen, and done is not asserted. If enable drops in DONE, the done pulse is deferred to the first enabled cycle. Latency extends by the number of disabled cycles.
- start while busy=1 or in DONE: ignored, with no effect on the operation in flight.
- start coincident with done: ignored; a new start is accepted only in IDLE.
- q1..q8 hold their last values between done pulses.
- Reset mid-operation: next edge returns to IDLE with all outputs at reset values. The partial result is discarded.
- Input operands are sampled only at the accepted start; later input changes do not affect the result.

Optional Feature:
- Macro: CDF_MIN_SUB_EN.
- When defined:
  - Adds input port cdf_min [DATA_W-1:0], sampled with start.
  - Numerator = max(cdfval_todivN - cdf_min, 0) * SCALE.
  - Effective divisor = divisor - cdf_min.
  - If divisor <= cdf_min, this is treated as divide by zero (all lanes saturate).
  - Latency is unchanged.
- When undefined: no cdf_min port; plain cdf*SCALE/divisor.

Test Plan:
- divisor=1024, cdf lanes = 0,1,4,512,1023,1024,256,768, start pulse, enable high → done exactly 41 cycles after start; q = 0,0,0,127,254,255,63,191; busy high throughout.
- divisor=0, any cdf values (e.g. 5,0,...) → all q=255 at cycle 41, done one cycle.
- divisor=1024, cdf=2048 and 0xFFFFFFFF in lanes 1/2 → q1=q2=255 (saturated); other lanes correct.
- enable low for 5 cycles at iteration 10 → done at cycle 46, same q values as scenario 1. A second start pulsed at cycle 20 is ignored, so exactly one done is seen.
- reset asserted at iteration 20 → next cycle busy=0, done=0, q=0; new start then completes normally at +41.
- CDF_MIN_SUB_EN defined, cdf_min=100, divisor=1124, cdf = 100,1124,612,50,... → q = 0,255,127,0. With divisor=100, all q=255.

Source files
------------

// File: rtl/cdf_divider_array_if.sv
// Operand/result bundle between the CDF latch stage, the divider array and write-back.
// Carries the start/done handshake, enable stall, eight numerators, divisor and eight quotients.
// Optional cdf_min operand exists only when CDF_MIN_SUB_EN is defined.
interface cdf_divider_array_if #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 8
);
  logic              enable;
  logic              start;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] cdfval_todiv1;
  logic [DATA_W-1:0] cdfval_todiv2;
  logic [DATA_W-1:0] cdfval_todiv3;
  logic [DATA_W-1:0] cdfval_todiv4;
  logic [DATA_W-1:0] cdfval_todiv5;
  logic [DATA_W-1:0] cdfval_todiv6;
  logic [DATA_W-1:0] cdfval_todiv7;
  logic [DATA_W-1:0] cdfval_todiv8;
`ifdef CDF_MIN_SUB_EN
  logic [DATA_W-1:0] cdf_min;
`endif
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  q1, q2, q3, q4, q5, q6, q7, q8;

  modport master (
    output enable, start, divisor,
    output cdfval_todiv1, cdfval_todiv2, cdfval_todiv3, cdfval_todiv4,
    output cdfval_todiv5, cdfval_todiv6, cdfval_todiv7, cdfval_todiv8,
`ifdef CDF_MIN_SUB_EN
    output cdf_min,
`endif
    input  busy, done, q1, q2, q3, q4, q5, q6, q7, q8
  );

  modport slave (
    input  enable, start, divisor,
    input  cdfval_todiv1, cdfval_todiv2, cdfval_todiv3, cdfval_todiv4,
    input  cdfval_todiv5, cdfval_todiv6, cdfval_todiv7, cdfval_todiv8,
`ifdef CDF_MIN_SUB_EN
    input  cdf_min,
`endif
    output busy, done, q1, q2, q3, q4, q5, q6, q7, q8
  );
endinterface

// File: rtl/cdf_divider_array.sv
// Eight-lane restoring divider: q = sat(floor(cdf*SCALE/divisor)), one quotient bit per cycle.
// Latency DATA_W+OUT_W+1 enabled cycles from accepted start to the one-cycle done pulse.
// enable low freezes everything; start is accepted only in IDLE. CDF_MIN_SUB_EN adds cdf_min offset.
module cdf_divider_array #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 8,
  parameter int SCALE  = 255
) (
  input logic                clk,
  input logic                reset,
  cdf_divider_array_if.slave bus
);
  localparam int NW    = DATA_W + OUT_W;
  localparam int CNT_W = $clog2(NW);
  localparam int LANES = 8;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   div_q;
  logic                dz_q;
  logic                busy_q;
  logic                done_q;
  // num_q starts as the scaled numerator and is shifted left while quotient
  // bits enter from the LSB, so after NW steps it holds the full quotient.
  logic [NW-1:0]       num_q [LANES];
  logic [DATA_W:0]     rem_q [LANES];
  logic [OUT_W-1:0]    q_q   [LANES];

  logic [DATA_W-1:0]   cdf_in [LANES];
  logic [NW-1:0]       prod_d [LANES];
  logic [NW-1:0]       num_d  [LANES];
  logic [DATA_W:0]     rem_d  [LANES];
  logic [OUT_W-1:0]    sat_d  [LANES];
  logic [DATA_W-1:0]   div_d;
  logic                dz_d;

  assign cdf_in[0] = bus.cdfval_todiv1;
  assign cdf_in[1] = bus.cdfval_todiv2;
  assign cdf_in[2] = bus.cdfval_todiv3;
  assign cdf_in[3] = bus.cdfval_todiv4;
  assign cdf_in[4] = bus.cdfval_todiv5;
  assign cdf_in[5] = bus.cdfval_todiv6;
  assign cdf_in[6] = bus.cdfval_todiv7;
  assign cdf_in[7] = bus.cdfval_todiv8;

  // Scaled numerators and effective divisor, captured only on an accepted start.
  always_comb begin
`ifdef CDF_MIN_SUB_EN
    div_d = bus.divisor - bus.cdf_min;
    dz_d  = (bus.divisor <= bus.cdf_min);
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = (cdf_in[i] > bus.cdf_min)
                ? NW'(cdf_in[i] - bus.cdf_min) * NW'(SCALE)
                : '0;
    end
`else
    div_d = bus.divisor;
    dz_d  = (bus.divisor == '0);
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = NW'(cdf_in[i]) * NW'(SCALE);
    end
`endif
  end

  // One restoring step per lane plus the saturated view of the finished quotient.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      logic [DATA_W+1:0] trial;
      logic              ge;
      trial    = {rem_q[i], num_q[i][NW-1]};
      ge       = (trial >= {2'b00, div_q});
      rem_d[i] = ge ? (DATA_W+1)'(trial - {2'b00, div_q}) : (DATA_W+1)'(trial);
      num_d[i] = {num_q[i][NW-2:0], ge};
      sat_d[i] = (dz_q || (|num_q[i][NW-1:OUT_W])) ? {OUT_W{1'b1}}
                                                   : num_q[i][OUT_W-1:0];
    end
  end

  // Control FSM and lane datapath; done is a single-cycle pulse and never held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        num_q[i] <= '0;
        rem_q[i] <= '0;
        q_q[i]   <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (bus.enable) begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              div_q  <= div_d;
              dz_q   <= dz_d;
              cnt_q  <= '0;
              busy_q <= 1'b1;
              for (int i = 0; i < LANES; i++) begin
                num_q[i] <= prod_d[i];
                rem_q[i] <= '0;
              end
              state_q <= S_DIV;
            end
          end
          S_DIV: begin
            for (int i = 0; i < LANES; i++) begin
              num_q[i] <= num_d[i];
              rem_q[i] <= rem_d[i];
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NW - 1)) state_q <= S_DONE;
          end
          S_DONE: begin
            for (int i = 0; i < LANES; i++) q_q[i] <= sat_d[i];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.q1   = q_q[0];
  assign bus.q2   = q_q[1];
  assign bus.q3   = q_q[2];
  assign bus.q4   = q_q[3];
  assign bus.q5   = q_q[4];
  assign bus.q6   = q_q[5];
  assign bus.q7   = q_q[6];
  assign bus.q8   = q_q[7];
endmodule

// File: tb/tb_cdf_divider_array.sv
// Directed bench for the eight-lane CDF divider: latency, quotients, saturation,
// divide-by-zero, enable stalls, ignored starts and mid-operation reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cdf_divider_array;
  typedef logic [31:0] vec8_t [8];
  typedef logic [7:0]  q8_t   [8];

  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  cdf_divider_array_if #(.DATA_W(32), .OUT_W(8)) bus ();

  cdf_divider_array #(.DATA_W(32), .OUT_W(8), .SCALE(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_ops(input logic [31:0] d, input vec8_t c);
    bus.divisor       = d;
    bus.cdfval_todiv1 = c[0];
    bus.cdfval_todiv2 = c[1];
    bus.cdfval_todiv3 = c[2];
    bus.cdfval_todiv4 = c[3];
    bus.cdfval_todiv5 = c[4];
    bus.cdfval_todiv6 = c[5];
    bus.cdfval_todiv7 = c[6];
    bus.cdfval_todiv8 = c[7];
  endtask

  task automatic get_q(output q8_t q);
    q[0] = bus.q1; q[1] = bus.q2; q[2] = bus.q3; q[3] = bus.q4;
    q[4] = bus.q5; q[5] = bus.q6; q[6] = bus.q7; q[7] = bus.q8;
  endtask

  // Pulses start, then waits (bounded) for done. Optional stall window, a second
  // start pulse with different operands, and an early exit when reset is raised.
  task automatic run_op(input logic [31:0] d, input vec8_t c,
                        input int dis_at, input int dis_len,
                        input int start2_at, input int rst_at,
                        output int lat, output bit busy_bad);
    vec8_t junk;
    int cyc;
    for (int i = 0; i < 8; i++) junk[i] = 32'd7;
    busy_bad = 1'b0;
    @(negedge clk);
    drive_ops(d, c);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      cyc++;
      if (cyc == dis_at) bus.enable = 1'b0;
      if (cyc == dis_at + dis_len) bus.enable = 1'b1;
      if (cyc == start2_at) begin
        drive_ops(32'd3, junk);
        bus.start = 1'b1;
      end
      if (cyc == start2_at + 1) bus.start = 1'b0;
      if (cyc == rst_at) begin
        reset = 1'b1;
        break;
      end
    end
    lat = cyc;
  endtask

  task automatic test_reset();
    q8_t q;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    vecs++;
    if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done got %b expected 0", bus.done); end
    get_q(q);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (q[i] !== 8'd0) begin errs++; $display("FAIL reset_q lane %0d got %0d expected 0", i + 1, q[i]); end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    vec8_t c;
    q8_t   exp, q;
    int    lat;
    bit    bb;
    c   = '{32'd0, 32'd1, 32'd4, 32'd512, 32'd1023, 32'd1024, 32'd256, 32'd768};
    exp = '{8'd0, 8'd0, 8'd0, 8'd127, 8'd254, 8'd255, 8'd63, 8'd191};
    run_op(32'd1024, c, -100, 0, -100, -100, lat, bb);
    vecs++;
    if (lat !== 41) begin errs++; $display("FAIL basic_latency got %0d expected 41", lat); end
    vecs++;
    if (bb) begin errs++; $display("FAIL basic_busy got low-before-done expected high"); end
    vecs++;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL basic_busy_at_done got %b expected 0", bus.busy); end
    get_q(q);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (q[i] !== exp[i]) begin errs++; $display("FAIL basic_q lane %0d got %0d expected %0d", i + 1, q[i], exp[i]); end
    end
    // Done lasts one cycle and results hold afterwards.
    @(negedge clk);
    vecs++;
    if (bus.done !== 1'b0) begin errs++; $display("FAIL basic_done_width got %b expected 0", bus.done); end
    repeat (3) @(negedge clk);
    get_q(q);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (q[i] !== exp[i]) begin errs++; $display("FAIL basic_hold lane %0d got %0d expected %0d", i + 1, q[i], exp[i]); end
    end
  endtask

  task automatic test_div_zero();
    vec8_t c;
    q8_t   q;
    int    lat;
    bit    bb;
    c = '{32'd5, 32'd0, 32'd1, 32'd2, 32'd3, 32'd100, 32'hFFFF_FFFF, 32'd7};
    run_op(32'd0, c, -100, 0, -100, -100, lat, bb);
    vecs++;
    if (lat !== 41) begin errs++; $display("FAIL divzero_latency got %0d expected 41", lat); end
    get_q(q);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (q[i] !== 8'd255) begin errs++; $display("FAIL divzero_q lane %0d got %0d expected 255", i + 1, q[i]); end
    end
    @(negedge clk);
    vecs++;
    if (bus.done !== 1'b0) begin errs++; $display("FAIL divzero_done_width got %b expected 0", bus.done); end
  endtask

  task automatic test_saturation();
    vec8_t c;
    q8_t   exp, q;
    int    lat;
    bit    bb;
    c   = '{32'd2048, 32'hFFFF_FFFF, 32'd4, 32'd512, 32'd1023, 32'd1024, 32'd256, 32'd768};
    exp = '{8'd255, 8'd255, 8'd0, 8'd127, 8'd254, 8'd255, 8'd63, 8'd191};
    run_op(32'd1024, c, -100, 0, -100, -100, lat, bb);
    vecs++;
    if (lat !== 41) begin errs++; $display("FAIL sat_latency got %0d expected 41", lat); end
    get_q(q);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (q[i] !== exp[i]) begin errs++; $display("FAIL sat_q lane %0d got %0d expected %0d", i + 1, q[i], exp[i]); end
    end
  endtask

  task automatic test_enable_stall();
    vec8_t c;
    q8_t   exp, q;
    int    lat;
    int    extra;
    bit    bb;
    c   = '{32'd0, 32'd1, 32'd4, 32'd512, 32'd1023, 32'd1024, 32'd256, 32'd768};
    exp = '{8'd0, 8'd0, 8'd0, 8'd127, 8'd254, 8'd255, 8'd63, 8'd191};
    run_op(32'd1024, c, 10, 5, 20, -100, lat, bb);
    vecs++;
    if (lat !== 46) begin errs++; $display("FAIL stall_latency got %0d expected 46", lat); end
    vecs++;
    if (bb) begin errs++; $display("FAIL stall_busy got low-before-done expected high"); end
    get_q(q);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (q[i] !== exp[i]) begin errs++; $display("FAIL stall_q lane %0d got %0d expected %0d", i + 1, q[i], exp[i]); end
    end
    extra = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    vecs++;
    if (extra !== 0) begin errs++; $display("FAIL stall_second_start got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    vec8_t c;
    q8_t   exp, q;
    int    lat;
    bit    bb;
    c   = '{32'd0, 32'd1, 32'd4, 32'd512, 32'd1023, 32'd1024, 32'd256, 32'd768};
    exp = '{8'd0, 8'd0, 8'd0, 8'd127, 8'd254, 8'd255, 8'd63, 8'd191};
    run_op(32'd1024, c, -100, 0, -100, 20, lat, bb);
    @(negedge clk);
    reset = 1'b0;
    vecs++;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL midreset_busy got %b expected 0", bus.busy); end
    vecs++;
    if (bus.done !== 1'b0) begin errs++; $display("FAIL midreset_done got %b expected 0", bus.done); end
    get_q(q);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (q[i] !== 8'd0) begin errs++; $display("FAIL midreset_q lane %0d got %0d expected 0", i + 1, q[i]); end
    end
    run_op(32'd1024, c, -100, 0, -100, -100, lat, bb);
    vecs++;
    if (lat !== 41) begin errs++; $display("FAIL midreset_restart_latency got %0d expected 41", lat); end
    get_q(q);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (q[i] !== exp[i]) begin errs++; $display("FAIL midreset_restart_q lane %0d got %0d expected %0d", i + 1, q[i], exp[i]); end
    end
  endtask

`ifdef CDF_MIN_SUB_EN
  task automatic test_cdf_min();
    vec8_t c;
    q8_t   exp, q;
    int    lat;
    bit    bb;
    bus.cdf_min = 32'd100;
    c   = '{32'd100, 32'd1124, 32'd612, 32'd50, 32'd200, 32'd0, 32'd1000, 32'd2000};
    exp = '{8'd0, 8'd255, 8'd127, 8'd0, 8'd24, 8'd0, 8'd224, 8'd255};
    run_op(32'd1124, c, -100, 0, -100, -100, lat, bb);
    vecs++;
    if (lat !== 41) begin errs++; $display("FAIL cdfmin_latency got %0d expected 41", lat); end
    get_q(q);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (q[i] !== exp[i]) begin errs++; $display("FAIL cdfmin_q lane %0d got %0d expected %0d", i + 1, q[i], exp[i]); end
    end
    run_op(32'd100, c, -100, 0, -100, -100, lat, bb);
    get_q(q);
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (q[i] !== 8'd255) begin errs++; $display("FAIL cdfmin_zero lane %0d got %0d expected 255", i + 1, q[i]); end
    end
    bus.cdf_min = 32'd0;
  endtask
`endif

  initial begin
    vec8_t zero;
    vecs = 0;
    errs = 0;
    for (int i = 0; i < 8; i++) zero[i] = '0;
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.start  = 1'b0;
    drive_ops(32'd0, zero);
`ifdef CDF_MIN_SUB_EN
    bus.cdf_min = 32'd0;
`endif
    test_reset();
    test_basic();
    test_div_zero();
    test_saturation();
    test_enable_stall();
    test_reset_mid();
`ifdef CDF_MIN_SUB_EN
    test_cdf_min();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
